// File: rtl/merge_out_axis_packer.sv
`default_nettype none
// ============================================================================
//  Module   : merge_out_axis_packer
//  Purpose  : Drains the P=8 merger output FIFO (first-word-fall-through),
//             packs TPB = C_AXIS_TDATA_WIDTH/C_TUPLE_WIDTH tuples per beat and
//             streams them out over AXI4-Stream. Raises tlast on the
//             programmed beat count and pulses done when the job completes.
//  Ports    : m_axis_aclk/m_axis_areset - clock, synchronous active-high reset
//             start/cfg_num_beats       - job launch and job length in beats
//             busy/done                 - job in progress / end-of-job pulse
//             fifo_empty/fifo_data      - FIFO status and head tuple
//             fifo_deq                  - pop the FIFO head this cycle
//             m_axis_*                  - packed output stream
//             flush                     - only with MERGE_OUT_PACKER_FLUSH_EN:
//                                         emit the partial beat and end the job
//  Options  : `define MERGE_OUT_PACKER_FLUSH_EN adds the flush input.
//  Revision : 1.0 - initial release
// ============================================================================
module merge_out_axis_packer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_TUPLE_WIDTH      = 256,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  input  logic                            start,
  input  logic [C_CNT_WIDTH-1:0]          cfg_num_beats,
  output logic                            busy,
  output logic                            done,
`ifdef MERGE_OUT_PACKER_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            fifo_empty,
  input  logic [C_TUPLE_WIDTH-1:0]        fifo_data,
  output logic                            fifo_deq,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int TPB     = C_AXIS_TDATA_WIDTH / C_TUPLE_WIDTH;
  localparam int IDX_W   = (TPB > 1) ? $clog2(TPB) : 1;
  localparam int KEEP_W  = C_AXIS_TDATA_WIDTH / 8;
  localparam int TKEEP_W = C_TUPLE_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TPB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [C_CNT_WIDTH-1:0]        num_beats_q, num_beats_d;
  logic [C_CNT_WIDTH-1:0]        beats_issued_q, beats_issued_d;
  logic [IDX_W-1:0]              asm_idx_q, asm_idx_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] asm_data_q, asm_data_d;
  logic                          last_issued_q, last_issued_d;
  logic                          tvalid_q, tvalid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0]             tkeep_q, tkeep_d;
  logic                          tlast_q, tlast_d;

  logic                          run;
  logic                          out_stall;
  logic                          out_hs;
  logic [C_AXIS_TDATA_WIDTH-1:0] beat_full;
  logic [C_AXIS_TDATA_WIDTH-1:0] partial_word;
  logic [KEEP_W-1:0]             partial_keep;
  logic                          flush_act;
  logic                          flush_partial;
  logic                          flush_empty;

  assign run       = (state_q == ST_RUN);
  assign out_stall = tvalid_q & ~m_axis_tready;
  assign out_hs    = tvalid_q & m_axis_tready;

`ifdef MERGE_OUT_PACKER_FLUSH_EN
  assign flush_act     = run & flush;
  // Partial beat can only load when the output register frees up this cycle.
  assign flush_partial = flush_act & (asm_idx_q != '0) & ~out_stall;
  assign flush_empty   = flush_act & (asm_idx_q == '0);
`else
  assign flush_act     = 1'b0;
  assign flush_partial = 1'b0;
  assign flush_empty   = 1'b0;
`endif

  // Completed beat: held slots plus the tuple arriving into the top slot.
  always_comb begin
    beat_full = asm_data_q;
    beat_full[(TPB-1)*C_TUPLE_WIDTH +: C_TUPLE_WIDTH] = fifo_data;
  end

  // Partial beat: only the asm_idx filled slots survive; stale slots are zeroed.
  always_comb begin
    partial_word = '0;
    partial_keep = '0;
    for (int s = 0; s < TPB; s++) begin
      if (IDX_W'(s) < asm_idx_q) begin
        partial_word[s*C_TUPLE_WIDTH +: C_TUPLE_WIDTH] = asm_data_q[s*C_TUPLE_WIDTH +: C_TUPLE_WIDTH];
        partial_keep[s*TKEEP_W +: TKEEP_W] = {TKEEP_W{1'b1}};
      end
    end
  end

  // ---------------- state register ----------------
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (cfg_num_beats == '0) ? ST_FIN : ST_RUN;
      ST_RUN: begin
        // A flush with nothing assembled and nothing pending ends the job at once.
        if ((out_hs & tlast_q) | (flush_empty & ~out_stall)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_FIN);
    // Stop popping when the completing tuple would have nowhere to go.
    fifo_deq      = run & ~fifo_empty & ~((asm_idx_q == LAST_IDX) & out_stall)
                    & ~last_issued_q & ~flush_act;
    m_axis_tvalid = tvalid_q;
    m_axis_tdata  = tdata_q;
    m_axis_tkeep  = tkeep_q;
    m_axis_tlast  = tlast_q;
  end

  // ---------------- datapath ----------------
  always_comb begin
    num_beats_d    = num_beats_q;
    beats_issued_d = beats_issued_q;
    asm_idx_d      = asm_idx_q;
    asm_data_d     = asm_data_q;
    last_issued_d  = last_issued_q;
    tvalid_d       = tvalid_q;
    tdata_d        = tdata_q;
    tkeep_d        = tkeep_q;
    tlast_d        = tlast_q;

    if ((state_q == ST_IDLE) && start) begin
      num_beats_d    = cfg_num_beats;
      beats_issued_d = '0;
      asm_idx_d      = '0;
      last_issued_d  = 1'b0;
    end

    if (out_hs) tvalid_d = 1'b0;

    if (fifo_deq) begin
      asm_data_d[asm_idx_q*C_TUPLE_WIDTH +: C_TUPLE_WIDTH] = fifo_data;
      asm_idx_d = (asm_idx_q == LAST_IDX) ? '0 : asm_idx_q + IDX_W'(1);
      if (asm_idx_q == LAST_IDX) begin
        tvalid_d       = 1'b1;
        tdata_d        = beat_full;
        tkeep_d        = {KEEP_W{1'b1}};
        tlast_d        = (beats_issued_q == num_beats_q - C_CNT_WIDTH'(1));
        last_issued_d  = tlast_d;
        beats_issued_d = beats_issued_q + C_CNT_WIDTH'(1);
      end
    end

    if (flush_partial) begin
      tvalid_d       = 1'b1;
      tdata_d        = partial_word;
      tkeep_d        = partial_keep;
      tlast_d        = 1'b1;
      last_issued_d  = 1'b1;
      asm_idx_d      = '0;
      beats_issued_d = beats_issued_q + C_CNT_WIDTH'(1);
    end

    // Nothing assembled but a beat still waiting: make that beat the last one.
    if (flush_empty & out_stall) begin
      tlast_d       = 1'b1;
      last_issued_d = 1'b1;
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      num_beats_q    <= '0;
      beats_issued_q <= '0;
      asm_idx_q      <= '0;
      last_issued_q  <= 1'b0;
      tvalid_q       <= 1'b0;
      tdata_q        <= '0;
      tkeep_q        <= '0;
      tlast_q        <= 1'b0;
    end else begin
      num_beats_q    <= num_beats_d;
      beats_issued_q <= beats_issued_d;
      asm_idx_q      <= asm_idx_d;
      last_issued_q  <= last_issued_d;
      tvalid_q       <= tvalid_d;
      tdata_q        <= tdata_d;
      tkeep_q        <= tkeep_d;
      tlast_q        <= tlast_d;
    end
  end

  // Assembly slots are only meaningful below asm_idx, so they need no reset.
  always_ff @(posedge m_axis_aclk) begin
    asm_data_q <= asm_data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_merge_out_axis_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_merge_out_axis_packer
//  Purpose  : Self-checking bench for merge_out_axis_packer with TPB=2.
//             A FIFO model feeds tuples; expected beats go into a queue and
//             are compared as the DUT hands them off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_merge_out_axis_packer;

  localparam int AW = 512;
  localparam int TW = 256;
  localparam int CW = 32;
  localparam int KW = AW / 8;

  typedef struct {
    logic [AW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] cfg = '0;
  logic          tready = 1'b0;
  logic          busy, done, fifo_deq, tvalid, tlast;
  logic [AW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          fifo_empty;
  logic [TW-1:0] fifo_data;
`ifdef MERGE_OUT_PACKER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  // FIFO model: written by the stimulus block, popped by the DUT.
  logic [TW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            pop_cnt = 0;
  logic          fifo_clr = 1'b0;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_deq && !fifo_empty) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  merge_out_axis_packer #(
    .C_AXIS_TDATA_WIDTH(AW),
    .C_TUPLE_WIDTH     (TW),
    .C_CNT_WIDTH       (CW)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .start         (start),
    .cfg_num_beats (cfg),
    .busy          (busy),
    .done          (done),
`ifdef MERGE_OUT_PACKER_FLUSH_EN
    .flush         (flush),
`endif
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_deq      (fifo_deq),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast)
  );

  function automatic logic [TW-1:0] tup(input int i);
    logic [31:0] w;
    w = 32'hA5C30000 + 32'(i);
    return {(TW/32){w}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_tuple(input int i);
    mem[wr_ptr[5:0]] = tup(i);
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic fifo_drop;
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic add_exp(input logic [AW-1:0] d, input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    start = 1'b1;
    cfg   = n;
    tick();
    start = 1'b0;
    cfg   = 32'hDEAD_BEEF;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);     else n_pass++;
    n_checks++; if (done !== 1'b0)   $display("FAIL reset_done: got %b want 0", done);     else n_pass++;
    n_checks++; if (fifo_deq !== 1'b0) $display("FAIL reset_deq: got %b want 0", fifo_deq); else n_pass++;
    n_checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", tvalid); else n_pass++;
    n_checks++; if (tlast !== 1'b0)  $display("FAIL reset_tlast: got %b want 0", tlast);   else n_pass++;
    n_checks++; if (tdata !== '0)    $display("FAIL reset_tdata: got %h want 0", tdata);   else n_pass++;
    n_checks++; if (tkeep !== '0)    $display("FAIL reset_tkeep: got %h want 0", tkeep);   else n_pass++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic;
    int p0, hs_c, done_c;
    beat_t e;
    exp_q.delete();
    p0 = pop_cnt; hs_c = -1; done_c = -1;
    for (int i = 0; i < 4; i++) push_tuple(i);
    add_exp({tup(1), tup(0)}, {KW{1'b1}}, 1'b0);
    add_exp({tup(3), tup(2)}, {KW{1'b1}}, 1'b1);
    tready = 1'b1;
    pulse_start(2);
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL basic_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL basic_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL basic_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL basic_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 4) $display("FAIL basic_pops: got %0d want 4", pop_cnt - p0); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_width: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure;
    int p0, hs_c, done_c, seen;
    beat_t e;
    exp_q.delete();
    p0 = pop_cnt; hs_c = -1; done_c = -1; seen = 0;
    for (int i = 10; i < 16; i++) push_tuple(i);
    add_exp({tup(11), tup(10)}, {KW{1'b1}}, 1'b0);
    add_exp({tup(13), tup(12)}, {KW{1'b1}}, 1'b0);
    add_exp({tup(15), tup(14)}, {KW{1'b1}}, 1'b1);
    tready = 1'b0;
    pulse_start(3);
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (tvalid) seen = 1;
    end
    n_checks++; if (seen !== 1) $display("FAIL bp_first_valid: got %0d want 1", seen); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b1 || tdata !== exp_q[0].data || tlast !== 1'b0)
        $display("FAIL bp_hold: got %b/%h/%b want 1/%h/0", tvalid, tdata, tlast, exp_q[0].data);
      else n_pass++;
    end
    n_checks++; if (fifo_deq !== 1'b0) $display("FAIL bp_deq_stall: got %b want 0", fifo_deq); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 3) $display("FAIL bp_pops_stall: got %0d want 3", pop_cnt - p0); else n_pass++;
    tick();
    tready = 1'b1;
    for (int c = 0; c < 60 && done_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL bp_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL bp_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 6) $display("FAIL bp_pops: got %0d want 6", pop_cnt - p0); else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_gap;
    int p0, hs_c, done_c, seen;
    beat_t e;
    exp_q.delete();
    p0 = pop_cnt; hs_c = -1; done_c = -1; seen = 0;
    push_tuple(20);
    add_exp({tup(21), tup(20)}, {KW{1'b1}}, 1'b1);
    tready = 1'b1;
    pulse_start(1);
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (pop_cnt - p0 == 1) seen = 1;
    end
    n_checks++; if (seen !== 1) $display("FAIL gap_first_pop: got %0d want 1", seen); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_deq !== 1'b0 || tvalid !== 1'b0) $display("FAIL gap_idle: got deq=%b tvalid=%b want 0/0", fifo_deq, tvalid);
      else n_pass++;
    end
    tick();
    push_tuple(21);
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL gap_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL gap_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL gap_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL gap_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 2) $display("FAIL gap_pops: got %0d want 2", pop_cnt - p0); else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_beats;
    int p0, saw_valid;
    p0 = pop_cnt; saw_valid = 0;
    push_tuple(30);
    tready = 1'b1;
    start = 1'b1;
    cfg   = '0;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_early: got %b want 0", done); else n_pass++;
    tick();
    start = 1'b0;
    @(negedge clk);
    if (tvalid) saw_valid = 1;
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) $display("FAIL zero_done: got done=%b busy=%b want 1/1", done, busy); else n_pass++;
    @(negedge clk);
    if (tvalid) saw_valid = 1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_after: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
    n_checks++; if (saw_valid !== 0) $display("FAIL zero_tvalid: got %0d want 0", saw_valid); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 0) $display("FAIL zero_pops: got %0d want 0", pop_cnt - p0); else n_pass++;
    tick();
    fifo_drop();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_busy_start;
    int p0, hs_c, done_c, seen, extra;
    beat_t e;
    exp_q.delete();
    p0 = pop_cnt; hs_c = -1; done_c = -1; seen = 0; extra = 0;
    for (int i = 40; i < 44; i++) push_tuple(i);
    add_exp({tup(41), tup(40)}, {KW{1'b1}}, 1'b1);
    tready = 1'b0;
    pulse_start(1);
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (tvalid) seen = 1;
    end
    tick();
    pulse_start(7);
    tready = 1'b1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL busy_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL busy_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL busy_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || tvalid) extra = extra + 1;
    end
    n_checks++; if (extra !== 0) $display("FAIL busy_ignored_start: got %0d active cycles want 0", extra); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 2) $display("FAIL busy_pops: got %0d want 2", pop_cnt - p0); else n_pass++;
    tick();
    fifo_drop();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid;
    int hs_c, done_c;
    beat_t e;
    exp_q.delete();
    hs_c = -1; done_c = -1;
    for (int i = 50; i < 58; i++) push_tuple(i);
    add_exp({tup(51), tup(50)}, {KW{1'b1}}, 1'b0);
    tready = 1'b1;
    pulse_start(4);
    for (int c = 0; c < 20 && hs_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        e = exp_q.pop_front();
        if (tdata !== e.data || tlast !== e.last)
          $display("FAIL rstmid_beat1: got %h/%b want %h/%b", tdata, tlast, e.data, e.last);
        else n_pass++;
        hs_c = c;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fifo_deq !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || tkeep !== '0)
      $display("FAIL rstmid_outputs: got busy=%b done=%b deq=%b tvalid=%b tlast=%b keep=%h want all 0", busy, done, fifo_deq, tvalid, tlast, tkeep);
    else n_pass++;
    tick();
    rst = 1'b0;
    fifo_drop();
    exp_q.delete();
    hs_c = -1;
    push_tuple(58);
    push_tuple(59);
    add_exp({tup(59), tup(58)}, {KW{1'b1}}, 1'b1);
    pulse_start(1);
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rstmid_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL rstmid_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL rstmid_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL rstmid_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    tick();
  endtask

`ifdef MERGE_OUT_PACKER_FLUSH_EN
  // ---------------------------------------------------------------------------
  task automatic test_flush;
    int p0, hs_c, done_c, seen;
    beat_t e;
    exp_q.delete();
    p0 = pop_cnt; hs_c = -1; done_c = -1; seen = 0;
    push_tuple(60);
    add_exp({{TW{1'b0}}, tup(60)}, {{(KW/2){1'b0}}, {(KW/2){1'b1}}}, 1'b1);
    tready = 1'b1;
    pulse_start(5);
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (pop_cnt - p0 == 1) seen = 1;
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      if (c > 0 || !tvalid) @(negedge clk);
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL flush_beat: unexpected beat %h", tdata);
        else begin
          e = exp_q.pop_front();
          if (tdata !== e.data || tkeep !== e.keep || tlast !== e.last)
            $display("FAIL flush_beat: got %h/%h/%b want %h/%h/%b", tdata, tkeep, tlast, e.data, e.keep, e.last);
          else n_pass++;
        end
        hs_c = c;
      end
      if (done) done_c = c;
    end
    n_checks++; if (done_c !== hs_c + 1) $display("FAIL flush_done_time: got %0d want %0d", done_c, hs_c + 1); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL flush_missing: got %0d left want 0", exp_q.size()); else n_pass++;
    n_checks++; if (pop_cnt - p0 !== 1) $display("FAIL flush_pops: got %0d want 1", pop_cnt - p0); else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_zero_beats();
    test_busy_start();
    test_reset_mid();
`ifdef MERGE_OUT_PACKER_FLUSH_EN
    fifo_drop();
    test_flush();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
